// File: rtl/key_time_set.sv
// key_time_set: turns mode/sel/inc/alarm push-keys into the time-load bus,
// alarm digits and alarm enable for the clock/alarm counter block.
module key_time_set #(
    parameter int HOLD_CYCLES   = 1500,
    parameter int REPEAT_CYCLES = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_mode,
    input  logic       key_sel,
    input  logic       key_inc,
    input  logic       key_alarm,
    input  logic [3:0] cur_sec_ge,
    input  logic [3:0] cur_sec_shi,
    input  logic [3:0] cur_min_ge,
    input  logic [3:0] cur_min_shi,
    input  logic [3:0] cur_hour_ge,
    input  logic [3:0] cur_hour_shi,
    output logic       set_time_finish,
    output logic [3:0] set_sec_ge,
    output logic [3:0] set_sec_shi,
    output logic [3:0] set_min_ge,
    output logic [3:0] set_min_shi,
    output logic [3:0] set_hour_ge,
    output logic [3:0] set_hour_shi,
    output logic       clock_en,
    output logic [3:0] clock_min_ge,
    output logic [3:0] clock_min_shi,
    output logic [3:0] clock_hour_ge,
    output logic [3:0] clock_hour_shi,
    output logic [1:0] mode,
    output logic [1:0] edit_field
);
    localparam int MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] HOLD_END = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REP_END  = CW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {RUN = 2'd0, SET_TIME = 2'd1, SET_ALARM = 2'd2} mode_t;

    mode_t         r_mode, w_next_mode;
    logic          r_prev_mode, r_prev_sel, r_prev_inc, r_prev_alarm;
    logic [1:0]    r_field;
    logic [7:0]    r_set_hour, r_set_min, r_set_sec, r_clk_hour, r_clk_min;
    logic          r_clock_en, r_rpt;
    logic [CW-1:0] r_cnt;
    logic          w_mode_p, w_sel_p, w_inc_p, w_alarm_p, w_inc_held, w_rpt_hit, w_inc_ev;

    function automatic logic [7:0] inc_sixty(input logic [7:0] v);
        return (v[3:0] > 4'd9 || v[7:4] > 4'd5 || v == 8'h59) ? 8'h00 :
               (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] inc_hour(input logic [7:0] v);
        return (v[3:0] > 4'd9 || v >= 8'h23) ? 8'h00 :
               (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign w_mode_p   = r_prev_mode & ~key_mode;
    assign w_sel_p    = r_prev_sel & ~key_sel;
    assign w_inc_p    = r_prev_inc & ~key_inc;
    assign w_alarm_p  = r_prev_alarm & ~key_alarm;
    assign w_inc_held = ~r_prev_inc & ~key_inc;
    // r_rpt selects between the initial hold delay and the repeat period
    assign w_rpt_hit  = w_inc_held & (r_cnt == (r_rpt ? REP_END : HOLD_END));
    assign w_inc_ev   = w_inc_p | w_rpt_hit;

    always_comb begin
        w_next_mode = r_mode;
        if (w_mode_p) begin
            case (r_mode)
                RUN:      w_next_mode = SET_TIME;
                SET_TIME: w_next_mode = SET_ALARM;
                default:  w_next_mode = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mode       <= RUN;
            r_prev_mode  <= 1'b1;
            r_prev_sel   <= 1'b1;
            r_prev_inc   <= 1'b1;
            r_prev_alarm <= 1'b1;
            r_field      <= 2'd0;
            r_set_hour   <= 8'h00;
            r_set_min    <= 8'h00;
            r_set_sec    <= 8'h00;
            r_clk_hour   <= 8'h00;
            r_clk_min    <= 8'h00;
            r_clock_en   <= 1'b0;
            r_cnt        <= '0;
            r_rpt        <= 1'b0;
        end else begin
            r_mode       <= w_next_mode;
            r_prev_mode  <= key_mode;
            r_prev_sel   <= key_sel;
            r_prev_inc   <= key_inc;
            r_prev_alarm <= key_alarm;
            r_cnt        <= (w_mode_p || !w_inc_held || w_rpt_hit) ? '0 : r_cnt + CW'(1);
            r_rpt        <= !w_mode_p && w_inc_held && (r_rpt || w_rpt_hit);
            if (w_alarm_p)
                r_clock_en <= ~r_clock_en;
            if (w_mode_p) begin
                r_field <= 2'd0;
                if (r_mode == RUN) begin
                    r_set_hour <= {cur_hour_shi, cur_hour_ge};
                    r_set_min  <= {cur_min_shi, cur_min_ge};
                    r_set_sec  <= {cur_sec_shi, cur_sec_ge};
                end
            end else if (r_mode == SET_TIME) begin
                if (w_sel_p)
                    r_field <= (r_field == 2'd2) ? 2'd0 : r_field + 2'd1;
                else if (w_inc_ev) begin
                    if (r_field == 2'd0) r_set_hour <= inc_hour(r_set_hour);
                    if (r_field == 2'd1) r_set_min  <= inc_sixty(r_set_min);
                    if (r_field == 2'd2) r_set_sec  <= inc_sixty(r_set_sec);
                end
            end else if (r_mode == SET_ALARM) begin
                if (w_sel_p)
                    r_field <= {1'b0, ~r_field[0]};
                else if (w_inc_ev) begin
                    if (r_field[0]) r_clk_min  <= inc_sixty(r_clk_min);
                    else            r_clk_hour <= inc_hour(r_clk_hour);
                end
            end
        end
    end

    assign set_time_finish = (r_mode != SET_TIME);
    assign mode            = r_mode;
    assign edit_field      = r_field;
    assign clock_en        = r_clock_en;
    assign {set_hour_shi, set_hour_ge}     = r_set_hour;
    assign {set_min_shi, set_min_ge}       = r_set_min;
    assign {set_sec_shi, set_sec_ge}       = r_set_sec;
    assign {clock_hour_shi, clock_hour_ge} = r_clk_hour;
    assign {clock_min_shi, clock_min_ge}   = r_clk_min;
endmodule

// File: tb/tb_key_time_set.sv
// tb_key_time_set: directed test-plan sequences plus random key traffic,
// every cycle compared against a decimal-arithmetic reference model.
module tb_key_time_set;
    localparam int HOLD = 10;
    localparam int REP  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  keys = 4'hF;
    logic [23:0] cur = 24'h0;
    logic        stf, en;
    logic [3:0]  s_sg, s_ss, s_mg, s_ms, s_hg, s_hs, c_mg, c_ms, c_hg, c_hs;
    logic [1:0]  mode, field;
    logic [23:0] w_set;
    logic [15:0] w_alm;
    int          checks = 0, errors = 0;

    int          m_mode, m_field, m_len;
    bit          m_en;
    bit   [3:0]  m_prev;
    logic [7:0]  m_set[3];
    logic [7:0]  m_alm[2];
    logic [7:0]  exp_sec[4] = '{8'h57, 8'h58, 8'h59, 8'h00};

    key_time_set #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_mode(keys[0]), .key_sel(keys[1]), .key_inc(keys[2]), .key_alarm(keys[3]),
        .cur_sec_ge(cur[3:0]), .cur_sec_shi(cur[7:4]),
        .cur_min_ge(cur[11:8]), .cur_min_shi(cur[15:12]),
        .cur_hour_ge(cur[19:16]), .cur_hour_shi(cur[23:20]),
        .set_time_finish(stf),
        .set_sec_ge(s_sg), .set_sec_shi(s_ss), .set_min_ge(s_mg), .set_min_shi(s_ms),
        .set_hour_ge(s_hg), .set_hour_shi(s_hs),
        .clock_en(en),
        .clock_min_ge(c_mg), .clock_min_shi(c_ms), .clock_hour_ge(c_hg), .clock_hour_shi(c_hs),
        .mode(mode), .edit_field(field)
    );

    assign w_set = {s_hs, s_hg, s_ms, s_mg, s_ss, s_sg};
    assign w_alm = {c_hs, c_hg, c_ms, c_mg};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] bump(input logic [7:0] b, input bit hour);
        int s = int'(b[7:4]);
        int g = int'(b[3:0]);
        int v = s * 10 + g;
        if (hour) v = (g > 9 || v >= 23) ? 0 : v + 1;
        else      v = (g > 9 || s > 5) ? 0 : (v + 1) % 60;
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic model_step();
        bit [3:0] p;
        bit inc_ev;
        if (!rst_n) begin
            m_mode = 0; m_field = 0; m_len = 0; m_en = 0; m_prev = 4'hF;
            m_set = '{8'h0, 8'h0, 8'h0};
            m_alm = '{8'h0, 8'h0};
            return;
        end
        p = m_prev & ~keys;
        inc_ev = 0;
        if (p[2]) begin
            m_len = 0; inc_ev = 1;
        end else if (!keys[2] && !m_prev[2]) begin
            m_len++;
            if (m_len >= HOLD && (m_len - HOLD) % REP == 0) inc_ev = 1;
        end else m_len = 0;
        if (p[3]) m_en = !m_en;
        if (p[0]) begin
            m_len = 0;
            if (m_mode == 0) m_set = '{cur[23:16], cur[15:8], cur[7:0]};
            m_mode = (m_mode + 1) % 3;
            m_field = 0;
        end else if (m_mode == 1) begin
            if (p[1]) m_field = (m_field + 1) % 3;
            else if (inc_ev) m_set[m_field] = bump(m_set[m_field], m_field == 0);
        end else if (m_mode == 2) begin
            if (p[1]) m_field = 1 - m_field;
            else if (inc_ev) m_alm[m_field] = bump(m_alm[m_field], m_field == 0);
        end
        m_prev = keys;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("mode", 32'(mode), 32'(m_mode));
        check("edit_field", 32'(field), 32'(m_field));
        check("set_time_finish", 32'(stf), 32'(m_mode != 1));
        check("clock_en", 32'(en), 32'(m_en));
        check("set_bus", 32'(w_set), 32'({m_set[0], m_set[1], m_set[2]}));
        check("alarm_bus", 32'(w_alm), 32'({m_alm[0], m_alm[1]}));
    endtask

    task automatic hit(input int k);
        keys[k] = 1'b0;
        tick();
        keys[k] = 1'b1;
        tick();
    endtask

    initial begin
        keys[2] = 1'b0;
        repeat (3) tick();
        keys[2] = 1'b1;
        rst_n = 1'b1;
        tick();
        check("rst_mode", 32'(mode), 0);
        check("rst_stf", 32'(stf), 1);
        check("rst_en", 32'(en), 0);
        check("rst_digits", 32'({w_set, w_alm}), 0);

        cur = 24'h123456;
        keys[0] = 1'b0;
        tick();
        check("capture", 32'(w_set), 32'h123456);
        check("capture_stf", 32'(stf), 0);
        keys[0] = 1'b1;
        tick();
        hit(1);
        hit(1);
        check("field_sec", 32'(field), 2);
        for (int i = 0; i < 4; i++) begin
            keys[2] = 1'b0;
            tick();
            check("sec_inc", 32'(w_set[7:0]), 32'(exp_sec[i]));
            keys[2] = 1'b1;
            tick();
        end
        check("sec_keep_hm", 32'(w_set[23:8]), 32'h1234);
        hit(0);
        check("to_alarm_stf", 32'(stf), 1);
        check("to_alarm_mode", 32'(mode), 2);

        repeat (7) hit(2);
        hit(1);
        repeat (60) hit(2);
        check("alarm_digits", 32'(w_alm), 32'h0700);
        hit(3);
        check("alarm_en", 32'(en), 1);
        hit(0);
        check("back_run", 32'(mode), 0);

        cur = 24'h220037;
        hit(0);
        keys[2] = 1'b0;
        tick();
        check("hour23", 32'(w_set[23:16]), 32'h23);
        keys[2] = 1'b1;
        tick();
        keys[2] = 1'b0;
        tick();
        check("hour00", 32'(w_set[23:16]), 32'h00);
        check("hour_keep_ms", 32'(w_set[15:0]), 32'h0037);
        keys[2] = 1'b1;
        tick();

        hit(1);
        keys[2] = 1'b0;
        tick();
        check("rpt_press", 32'(w_set[15:8]), 32'h01);
        for (int i = 1; i <= 22; i++) begin
            tick();
            if (i == 9) check("rpt_before_hold", 32'(w_set[15:8]), 32'h01);
            if (i == 10) check("rpt_hold", 32'(w_set[15:8]), 32'h02);
        end
        check("rpt_final", 32'(w_set[15:8]), 32'h05);
        keys[2] = 1'b1;
        tick();

        keys[2:0] = 3'b000;
        tick();
        check("prio_mode", 32'(mode), 2);
        check("prio_bus", 32'(w_set), 32'h000537);
        keys[2:0] = 3'b111;
        tick();

        hit(0);
        hit(0);
        check("edit_stf", 32'(stf), 0);
        rst_n = 1'b0;
        tick();
        check("midrst_stf", 32'(stf), 1);
        check("midrst_mode", 32'(mode), 0);
        rst_n = 1'b1;
        tick();

        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 99) < 3)  keys[0] = ~keys[0];
            if ($urandom_range(0, 99) < 8)  keys[1] = ~keys[1];
            if ($urandom_range(0, 99) < 6)  keys[2] = ~keys[2];
            if ($urandom_range(0, 99) < 10) keys[3] = ~keys[3];
            if ($urandom_range(0, 9) == 0)
                cur = $urandom_range(0, 1) ? 24'($urandom)
                    : {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9)),
                       4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)),
                       4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
            rst_n = ($urandom_range(0, 299) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
